hpm_counters: RTL and testbench

Parametrised machine-mode counter/performance-monitor unit that replaces the fixed mcycle/minstret pair in the exec-stage CSR file with configurable-width counters. Provides mcycle, minstret, NUM_HPM programmable mhpmcounterN with mhpmeventN selectors, mcountinhibit and mcounteren, plus user-mode read aliases. The block sits beside the CSR file and is queried on the same exec CSR access cycle. The CSR file muxes csr_hit/csr_rdata/csr_illegal into its own result and exception.

---
 rtl/hpm_counters_pkg.sv | 46 ++++
 rtl/hpm_counter_slice.sv | 73 +++++++
 rtl/hpm_counters.sv | 147 ++++++++++++++
 tb/tb_hpm_counters.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_counters_pkg.sv
// Shared constants and types for the machine-mode counter / HPM unit.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN (overflow flag, M-mode inhibit, lcofi_irq).
package hpm_counters_pkg;

   localparam int DEF_NUM_HPM    = 4;
   localparam int DEF_CNT_WIDTH  = 64;
   localparam int DEF_NUM_EVENTS = 8;
   localparam int DEF_XLEN       = 64;

   // CSR addresses; the HPM bases anchor the 32-entry blocks
   localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;

   typedef logic [4:0] cnt_idx_t;

   // counter index inside a block (addr[4:0])
   localparam cnt_idx_t IDX_CYCLE   = 5'd0;
   localparam cnt_idx_t IDX_TIME    = 5'd1;
   localparam cnt_idx_t IDX_INSTRET = 5'd2;
   localparam int       HPM_FIRST   = 3;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_e;

   // selector value 0 means "no event"; ids 1..NUM_EVENTS map to events[id-1]
   typedef enum logic [7:0] {
      EVT_NONE  = 8'd0,
      EVT_FIRST = 8'd1,
      EVT_LAST  = 8'd255
   } event_id_e;

   // implemented bits of mcountinhibit / mcounteren: CY, IR and the HPM range (TM is absent)
   function automatic logic [31:0] cnt_mask(int num_hpm);
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int i = 0; i < num_hpm; i++) m[HPM_FIRST+i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One programmable counter with its event selector and inhibit gating.
// With HPM_OVERFLOW_IRQ_EN the selector also carries OF (bit XLEN-1) and MINH (bit XLEN-2).
module hpm_counter_slice
   import hpm_counters_pkg::*;
#(
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int NUM_EVENTS = DEF_NUM_EVENTS,
   parameter int XLEN       = DEF_XLEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] events_q,
   input  logic                  inhibit,
   input  logic                  priv_m,
   input  logic                  cnt_we,
   input  logic                  evt_we,
   input  logic [XLEN-1:0]       wdata,
   output logic [CNT_WIDTH-1:0]  count,
   output logic [XLEN-1:0]       event_rd,
   output logic                  of
);

   logic [7:0]   sel;
   logic [7:0]   sel_w;
   logic         sel_ok;
   logic [255:0] ev_ext;
   logic [63:0]  wext;
   logic         minh;
   logic         inc;

   assign wext   = 64'(wdata);
   assign sel_w  = wdata[7:0];
   assign sel_ok = (sel_w <= 8'(NUM_EVENTS));
   // shift by one so selector id k lands on events_q[k-1]; id 0 hits a constant 0
   assign ev_ext = 256'({events_q, 1'b0});
   assign inc    = (sel != EVT_NONE) && ev_ext[sel] && !inhibit && !(minh && priv_m);

   // counter: a software write replaces the value and drops that cycle's increment
   always_ff @(posedge clk or negedge rst)
      if (!rst)        count <= '0;
      else if (cnt_we) count <= wext[CNT_WIDTH-1:0];
      else if (inc)    count <= count + CNT_WIDTH'(1);

   // selector: out-of-range ids are stored as 0 (never counts)
   always_ff @(posedge clk or negedge rst)
      if (!rst)        sel <= '0;
      else if (evt_we) sel <= sel_ok ? sel_w : 8'd0;

`ifdef HPM_OVERFLOW_IRQ_EN
   logic wrap;
   assign wrap = inc && !cnt_we && (&count);

   // OF is sticky; a hardware wrap beats a same-cycle software clear
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         of   <= 1'b0;
         minh <= 1'b0;
      end else begin
         if (evt_we) minh <= wdata[XLEN-2];
         if (wrap)        of <= 1'b1;
         else if (evt_we) of <= wdata[XLEN-1];
      end

   assign event_rd = {of, minh, {(XLEN-10){1'b0}}, sel};
`else
   logic unused_priv;
   assign unused_priv = priv_m;
   assign of          = 1'b0;
   assign minh        = 1'b0;
   assign event_rd    = XLEN'(sel);
`endif

endmodule

// File: rtl/hpm_counters.sv
// Machine-mode counters: mcycle, minstret, NUM_HPM programmable HPM counters,
// mcountinhibit, mcounteren and the user read aliases, answering exec-stage CSR accesses.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN (overflow flags and lcofi_irq).
module hpm_counters
   import hpm_counters_pkg::*;
#(
   parameter int NUM_HPM    = DEF_NUM_HPM,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int NUM_EVENTS = DEF_NUM_EVENTS,
   parameter int XLEN       = DEF_XLEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_retired,
   input  logic [NUM_EVENTS-1:0] events,
   input  logic [1:0]            privilege_mode,
   input  logic                  csr_valid,
   input  logic [11:0]           csr_addr,
   input  logic                  csr_we,
   input  logic [XLEN-1:0]       csr_wdata,
   output logic                  csr_hit,
   output logic [XLEN-1:0]       csr_rdata,
   output logic                  csr_illegal,
   output logic                  lcofi_irq
);

   localparam logic [31:0] CNT_MASK = cnt_mask(NUM_HPM);
   localparam logic [6:0]  BLK_EVT  = CSR_MHPMEVENT3[11:5];
   localparam logic [6:0]  BLK_MCNT = CSR_MHPMCOUNTER3[11:5];
   localparam logic [6:0]  BLK_UCNT = CSR_HPMCOUNTER3[11:5];

   logic [6:0]     blk;
   cnt_idx_t       idx;
   logic           is_counteren, is_inhibit, is_evt, is_mcnt, is_ucnt;
   logic           wr;
   logic           priv_m;
   logic [63:0]    wext;

   logic [CNT_WIDTH-1:0]                mcycle, minstret;
   logic [31:0]                         counteren, inhibit;
   logic                                retire_q;
   logic [NUM_EVENTS-1:0]               events_q;
   logic [NUM_HPM-1:0][CNT_WIDTH-1:0]   hpm_cnt;
   logic [NUM_HPM-1:0][XLEN-1:0]        hpm_evt;
   logic [NUM_HPM-1:0]                  hpm_of;
   logic [31:0][CNT_WIDTH-1:0]          cnt_view;
   logic [31:0][XLEN-1:0]               evt_view;

   assign blk    = csr_addr[11:5];
   assign idx    = csr_addr[4:0];
   assign priv_m = (privilege_mode == PRIV_M);
   assign wext   = 64'(csr_wdata);

   // unimplemented HPM slots inside the blocks still hit and read as zero
   assign is_counteren = (csr_addr == CSR_MCOUNTEREN);
   assign is_inhibit   = (csr_addr == CSR_MCOUNTINHIBIT);
   assign is_evt       = (blk == BLK_EVT) && (idx >= cnt_idx_t'(HPM_FIRST));
   assign is_mcnt      = (blk == BLK_MCNT) && (idx != IDX_TIME);
   assign is_ucnt      = (blk == BLK_UCNT);
   assign csr_hit      = is_counteren | is_inhibit | is_evt | is_mcnt | is_ucnt;

   // user aliases are read-only; below M-mode they also need the mcounteren bit
   assign csr_illegal = csr_valid && is_ucnt && (csr_we || (!priv_m && !counteren[idx]));
   assign wr          = csr_valid && csr_we && csr_hit && !csr_illegal;

   // retire/event inputs get one register stage of slack
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         retire_q <= 1'b0;
         events_q <= '0;
      end else begin
         retire_q <= inst_retired;
         events_q <= events;
      end

   // control registers: only implemented bits are stored
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         counteren <= '0;
         inhibit   <= '0;
      end else begin
         if (wr && is_counteren) counteren <= csr_wdata[31:0] & CNT_MASK;
         if (wr && is_inhibit)   inhibit   <= csr_wdata[31:0] & CNT_MASK;
      end

   // mcycle: free-running unless inhibited; a write wins over the increment
   always_ff @(posedge clk or negedge rst)
      if (!rst)                              mcycle <= '0;
      else if (wr && is_mcnt && idx == IDX_CYCLE) mcycle <= wext[CNT_WIDTH-1:0];
      else if (!inhibit[0])                  mcycle <= mcycle + CNT_WIDTH'(1);

   // minstret: counts buffered retirements; a write wins over the increment
   always_ff @(posedge clk or negedge rst)
      if (!rst)                                  minstret <= '0;
      else if (wr && is_mcnt && idx == IDX_INSTRET) minstret <= wext[CNT_WIDTH-1:0];
      else if (retire_q && !inhibit[2])          minstret <= minstret + CNT_WIDTH'(1);

   for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
      hpm_counter_slice #(
         .CNT_WIDTH  (CNT_WIDTH),
         .NUM_EVENTS (NUM_EVENTS),
         .XLEN       (XLEN)
      ) u_slice (
         .clk      (clk),
         .rst      (rst),
         .events_q (events_q),
         .inhibit  (inhibit[HPM_FIRST+i]),
         .priv_m   (priv_m),
         .cnt_we   (wr && is_mcnt && idx == cnt_idx_t'(HPM_FIRST+i)),
         .evt_we   (wr && is_evt  && idx == cnt_idx_t'(HPM_FIRST+i)),
         .wdata    (csr_wdata),
         .count    (hpm_cnt[i]),
         .event_rd (hpm_evt[i]),
         .of       (hpm_of[i])
      );
   end

   // read mux: every counter block is a 32-entry view indexed by addr[4:0]
   always_comb begin
      cnt_view              = '0;
      evt_view              = '0;
      cnt_view[IDX_CYCLE]   = mcycle;
      cnt_view[IDX_TIME]    = mcycle;
      cnt_view[IDX_INSTRET] = minstret;
      for (int i = 0; i < NUM_HPM; i++) begin
         cnt_view[HPM_FIRST+i] = hpm_cnt[i];
         evt_view[HPM_FIRST+i] = hpm_evt[i];
      end
      csr_rdata = '0;
      if (is_counteren)          csr_rdata = XLEN'(counteren);
      else if (is_inhibit)       csr_rdata = XLEN'(inhibit);
      else if (is_evt)           csr_rdata = evt_view[idx];
      else if (is_mcnt || is_ucnt) csr_rdata = XLEN'(cnt_view[idx]);
   end

`ifdef HPM_OVERFLOW_IRQ_EN
   // interrupt follows the OF flags by one edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) lcofi_irq <= 1'b0;
      else      lcofi_irq <= |hpm_of;
`else
   logic unused_of;
   assign unused_of = |hpm_of;
   assign lcofi_irq = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counters.sv
// Self-checking bench for hpm_counters: directed scenarios plus a randomized run,
// all compared against a CSR-level reference model kept in this file.
module tb_hpm_counters;
   localparam int NUM_HPM = 4, CNT_WIDTH = 64, NUM_EVENTS = 8, XLEN = 64;

   logic                  clk = 1'b0, rst = 1'b0, inst_retired = 1'b0;
   logic [NUM_EVENTS-1:0] events = '0;
   logic [1:0]            privilege_mode = 2'b11;
   logic                  csr_valid = 1'b0, csr_we = 1'b0;
   logic [11:0]           csr_addr = '0;
   logic [XLEN-1:0]       csr_wdata = '0;
   logic                  csr_hit, csr_illegal, lcofi_irq;
   logic [XLEN-1:0]       csr_rdata;

   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   hpm_counters #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(CNT_WIDTH), .NUM_EVENTS(NUM_EVENTS), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .inst_retired(inst_retired), .events(events),
      .privilege_mode(privilege_mode), .csr_valid(csr_valid), .csr_addr(csr_addr),
      .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_hit(csr_hit), .csr_rdata(csr_rdata),
      .csr_illegal(csr_illegal), .lcofi_irq(lcofi_irq));

   // ---------------- reference model ----------------
   logic [63:0]           m_cycle, m_instret;
   logic [63:0]           m_hpm  [NUM_HPM];
   logic [7:0]            m_sel  [NUM_HPM];
   logic                  m_of   [NUM_HPM];
   logic                  m_minh [NUM_HPM];
   logic [31:0]           m_inh, m_en;
   logic                  m_lcofi, p_ret;
   logic [NUM_EVENTS-1:0] p_ev;

   function automatic logic [31:0] m_mask();
      logic [31:0] m = 32'h5;
      for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
      return m;
   endfunction

   function automatic bit m_hit(logic [11:0] a);
      return a == 12'h306 || a == 12'h320 || (a >= 12'h323 && a <= 12'h33F) ||
             a == 12'hB00 || (a >= 12'hB02 && a <= 12'hB1F) || (a >= 12'hC00 && a <= 12'hC1F);
   endfunction

   function automatic logic [63:0] m_read(logic [11:0] a);
      int n;
      if (a == 12'h306) return {32'd0, m_en};
      if (a == 12'h320) return {32'd0, m_inh};
      if (a >= 12'h323 && a <= 12'h33F) begin
         n = int'(a) - 'h323;
         return (n < NUM_HPM) ? {m_of[n], m_minh[n], 54'd0, m_sel[n]} : 64'd0;
      end
      if (a == 12'hB00 || a == 12'hC00 || a == 12'hC01) return m_cycle;
      if (a == 12'hB02 || a == 12'hC02) return m_instret;
      if ((a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hC03 && a <= 12'hC1F)) begin
         n = int'(a[4:0]) - 3;
         return (n < NUM_HPM) ? m_hpm[n] : 64'd0;
      end
      return 64'd0;
   endfunction

   function automatic bit m_illegal(logic v, logic [11:0] a, logic we, logic [1:0] pr);
      return v && m_hit(a) && a[11:8] == 4'hC && (we || (pr != 2'b11 && !m_en[a[4:0]]));
   endfunction

   task automatic model_reset();
      m_cycle = 0; m_instret = 0; m_inh = 0; m_en = 0; m_lcofi = 0; p_ret = 0; p_ev = '0;
      for (int i = 0; i < NUM_HPM; i++) begin
         m_hpm[i] = 0; m_sel[i] = 0; m_of[i] = 0; m_minh[i] = 0;
      end
   endtask

   // advance the model across one rising edge using the inputs currently applied
   task automatic model_edge();
      bit          wr, any_of;
      bit          wrap [NUM_HPM];
      logic [63:0] wd;
      int          n;
      wd = csr_wdata;
      wr = csr_valid && csr_we && m_hit(csr_addr) && !m_illegal(csr_valid, csr_addr, csr_we, privilege_mode);
      any_of = 0;
      for (int i = 0; i < NUM_HPM; i++) any_of |= m_of[i];
      if (!m_inh[0]) m_cycle = m_cycle + 1;
      if (p_ret && !m_inh[2]) m_instret = m_instret + 1;
      for (int i = 0; i < NUM_HPM; i++) begin
         wrap[i] = 0;
         if (m_sel[i] >= 1 && m_sel[i] <= NUM_EVENTS && p_ev[m_sel[i]-1] && !m_inh[3+i] &&
             !(m_minh[i] && privilege_mode == 2'b11)) begin
            m_hpm[i] = m_hpm[i] + 1;
            wrap[i]  = (m_hpm[i] == 0);
         end
      end
      if (wr) begin
         if (csr_addr == 12'h306) m_en = wd[31:0] & m_mask();
         else if (csr_addr == 12'h320) m_inh = wd[31:0] & m_mask();
         else if (csr_addr >= 12'h323 && csr_addr <= 12'h33F) begin
            n = int'(csr_addr) - 'h323;
            if (n < NUM_HPM) begin
               m_sel[n] = (wd[7:0] <= NUM_EVENTS) ? wd[7:0] : 8'd0;
`ifdef HPM_OVERFLOW_IRQ_EN
               m_minh[n] = wd[62];
               m_of[n]   = wd[63];
`endif
            end
         end
         else if (csr_addr == 12'hB00) m_cycle = wd;
         else if (csr_addr == 12'hB02) m_instret = wd;
         else if (csr_addr >= 12'hB03 && csr_addr <= 12'hB1F) begin
            n = int'(csr_addr[4:0]) - 3;
            if (n < NUM_HPM) begin
               m_hpm[n] = wd;
               wrap[n]  = 0;
            end
         end
      end
`ifdef HPM_OVERFLOW_IRQ_EN
      for (int i = 0; i < NUM_HPM; i++) if (wrap[i]) m_of[i] = 1'b1;
      m_lcofi = any_of;
`endif
      p_ret = inst_retired;
      p_ev  = events;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [11:0] a, logic we, logic [63:0] wd);
      csr_valid = v; csr_addr = a; csr_we = we; csr_wdata = wd;
   endtask

   task automatic idle();
      csr_valid = 1'b0; csr_we = 1'b0;
   endtask

   task automatic wr_csr(logic [11:0] a, logic [63:0] wd);
      drive(1'b1, a, 1'b1, wd);
      tick();
      idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [11:0] addrs [7] = '{12'h306, 12'h320, 12'h323, 12'hB00, 12'hB02, 12'hB03, 12'hC00};
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      foreach (addrs[k]) begin
         drive(1'b0, addrs[k], 1'b0, '0);
         #1;
         n_cmp++;
         if (csr_rdata !== 64'd0) begin
            n_err++; $display("FAIL reset_read %h: got %h want 0", addrs[k], csr_rdata);
         end
      end
      n_cmp++;
      if (lcofi_irq !== 1'b0) begin n_err++; $display("FAIL reset_lcofi: got %b want 0", lcofi_irq); end
      @(posedge clk); #1;
      rst = 1'b1;
      wr_csr(12'hB00, 64'h1234);
      tick(); tick();
      drive(1'b0, 12'hB00, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'h1236) begin n_err++; $display("FAIL precount_mcycle: got %h want 1236", csr_rdata); end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd0) begin n_err++; $display("FAIL async_reset_mcycle: got %h want 0", csr_rdata); end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      tick(); tick();
      drive(1'b0, 12'hB00, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd2) begin n_err++; $display("FAIL mcycle_after_release: got %h want 2", csr_rdata); end
   endtask

   task automatic test_event_count();
      events = '0;
      wr_csr(12'hB03, 64'd0);
      wr_csr(12'h323, 64'd2);
      events[1] = 1'b1;
      repeat (5) tick();
      events = '0;
      tick(); tick();
      drive(1'b1, 12'hB03, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd5 || csr_rdata !== m_read(12'hB03)) begin
         n_err++; $display("FAIL hpm3_five_pulses: got %h want 5 (model %h)", csr_rdata, m_read(12'hB03));
      end
      wr_csr(12'h323, 64'(NUM_EVENTS + 1));
      drive(1'b1, 12'h323, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd0) begin n_err++; $display("FAIL sel_out_of_range: got %h want 0", csr_rdata); end
      wr_csr(12'h323, 64'(NUM_EVENTS));
      drive(1'b1, 12'h323, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'(NUM_EVENTS)) begin
         n_err++; $display("FAIL sel_max: got %h want %h", csr_rdata, 64'(NUM_EVENTS));
      end
   endtask

   task automatic test_wrap();
      wr_csr(12'h323, 64'd2);
      events[1] = 1'b1;
      tick();
      wr_csr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 12'hB03, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         n_err++; $display("FAIL wrap_write_wins: got %h want all ones", csr_rdata);
      end
      tick();
      events = '0;
      n_cmp++;
      if (csr_rdata !== 64'd0 || m_read(12'hB03) !== 64'd0) begin
         n_err++; $display("FAIL wrap_to_zero: got %h want 0", csr_rdata);
      end
      drive(1'b1, 12'h323, 1'b0, '0);
      #1;
`ifdef HPM_OVERFLOW_IRQ_EN
      n_cmp++;
      if (csr_rdata !== 64'h8000_0000_0000_0002) begin
         n_err++; $display("FAIL of_set: got %h want 8000000000000002", csr_rdata);
      end
      n_cmp++;
      if (lcofi_irq !== 1'b0) begin n_err++; $display("FAIL lcofi_early: got %b want 0", lcofi_irq); end
      tick();
      n_cmp++;
      if (lcofi_irq !== 1'b1 || m_lcofi !== 1'b1) begin
         n_err++; $display("FAIL lcofi_set: got %b want 1", lcofi_irq);
      end
      wr_csr(12'h323, 64'd2);
      tick();
`else
      n_cmp++;
      if (csr_rdata !== 64'd2) begin n_err++; $display("FAIL no_of_bit: got %h want 2", csr_rdata); end
      tick();
      n_cmp++;
      if (lcofi_irq !== 1'b0) begin n_err++; $display("FAIL lcofi_tied: got %b want 0", lcofi_irq); end
      wr_csr(12'h323, 64'hC000_0000_0000_0002);
      drive(1'b1, 12'h323, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd2) begin n_err++; $display("FAIL of_minh_ignored: got %h want 2", csr_rdata); end
`endif
   endtask

   task automatic test_write_collision();
      inst_retired = 1'b1;
      tick();
      drive(1'b1, 12'hB00, 1'b1, 64'd100);
      tick();
      drive(1'b1, 12'hB02, 1'b1, 64'd50);
      tick();
      idle();
      drive(1'b1, 12'hB00, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd101) begin n_err++; $display("FAIL mcycle_after_write: got %0d want 101", csr_rdata); end
      drive(1'b1, 12'hB02, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'd50) begin n_err++; $display("FAIL minstret_write_wins: got %0d want 50", csr_rdata); end
      tick();
      inst_retired = 1'b0;
      n_cmp++;
      if (csr_rdata !== 64'd51) begin n_err++; $display("FAIL minstret_next: got %0d want 51", csr_rdata); end
   endtask

   task automatic test_privilege();
      privilege_mode = 2'b11;
      wr_csr(12'h306, 64'd0);
      privilege_mode = 2'b00;
      drive(1'b1, 12'hC03, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL umode_no_enable: got %b want 1", csr_illegal); end
      privilege_mode = 2'b11;
      wr_csr(12'h306, 64'h8);
      privilege_mode = 2'b00;
      drive(1'b1, 12'hC03, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_illegal !== 1'b0 || csr_rdata !== m_read(12'hB03)) begin
         n_err++; $display("FAIL umode_enabled: got ill=%b %h want ill=0 %h", csr_illegal, csr_rdata, m_read(12'hB03));
      end
      privilege_mode = 2'b11;
      wr_csr(12'h306, 64'hFFFF_FFFF);
      drive(1'b1, 12'h306, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'h7D) begin n_err++; $display("FAIL counteren_mask: got %h want 7d", csr_rdata); end
      drive(1'b1, 12'hC00, 1'b1, 64'd5);
      #1;
      n_cmp++;
      if (csr_illegal !== 1'b1) begin n_err++; $display("FAIL write_user_alias: got %b want 1", csr_illegal); end
      tick();
      drive(1'b1, 12'hB00, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata === 64'd5 || csr_rdata !== m_read(12'hB00)) begin
         n_err++; $display("FAIL alias_write_ignored: got %h want %h", csr_rdata, m_read(12'hB00));
      end
      drive(1'b1, 12'hB01, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_hit !== 1'b0) begin n_err++; $display("FAIL hit_b01: got %b want 0", csr_hit); end
      drive(1'b1, 12'h33F, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_hit !== 1'b1 || csr_rdata !== 64'd0) begin
         n_err++; $display("FAIL hit_33f: got hit=%b %h want hit=1 0", csr_hit, csr_rdata);
      end
   endtask

   task automatic test_inhibit();
      logic [63:0] c0, r0, h0;
      wr_csr(12'h323, 64'd2);
      wr_csr(12'h320, 64'h5);
      c0 = m_cycle; r0 = m_instret; h0 = m_hpm[0];
      events[1] = 1'b1; inst_retired = 1'b1;
      repeat (6) tick();
      events = '0; inst_retired = 1'b0;
      tick();
      drive(1'b1, 12'hB00, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== c0) begin n_err++; $display("FAIL inhibit_mcycle: got %h want %h", csr_rdata, c0); end
      drive(1'b1, 12'hB02, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== r0) begin n_err++; $display("FAIL inhibit_minstret: got %h want %h", csr_rdata, r0); end
      drive(1'b1, 12'hB03, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== h0 + 64'd6) begin n_err++; $display("FAIL hpm_runs: got %h want %h", csr_rdata, h0 + 64'd6); end
      wr_csr(12'h320, 64'hFFFF_FFFF);
      drive(1'b1, 12'h320, 1'b0, '0);
      #1;
      n_cmp++;
      if (csr_rdata !== 64'h7D) begin n_err++; $display("FAIL inhibit_mask: got %h want 7d", csr_rdata); end
      wr_csr(12'h320, 64'd0);
   endtask

   task automatic test_random();
      logic [11:0] addrs [24] = '{12'h306, 12'h320, 12'h321, 12'h323, 12'h324, 12'h326, 12'h327, 12'h33F,
                                  12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB06, 12'hB07, 12'hB1F,
                                  12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC05, 12'hC07, 12'h100, 12'h7FF};
      logic [11:0] a;
      logic [63:0] wd;
      for (int c = 0; c < 400; c++) begin
         events         = NUM_EVENTS'($urandom);
         inst_retired   = 1'($urandom);
         privilege_mode = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
         a  = addrs[$urandom_range(0, 23)];
         wd = {$urandom, $urandom};
         if (a[11:5] == 7'h19 && a != 12'h320) wd[7:0] = 8'($urandom_range(0, 12));
         if (a == 12'h320 && $urandom_range(0, 3) != 0) wd = '0;
         if (a[11:8] == 4'hB && $urandom_range(0, 1) == 1) wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         drive(1'($urandom), a, ($urandom_range(0, 3) == 0), wd);
         #1;
         n_cmp++;
         if (csr_hit !== 1'(m_hit(a)) || csr_rdata !== m_read(a) ||
             csr_illegal !== 1'(m_illegal(csr_valid, a, csr_we, privilege_mode))) begin
            n_err++;
            $display("FAIL random c%0d addr %h: got hit=%b rd=%h ill=%b want hit=%b rd=%h ill=%b", c, a,
                     csr_hit, csr_rdata, csr_illegal, m_hit(a), m_read(a),
                     m_illegal(csr_valid, a, csr_we, privilege_mode));
         end
         if (c % 8 == 0) begin
            n_cmp++;
            if (lcofi_irq !== m_lcofi) begin n_err++; $display("FAIL random_lcofi c%0d: got %b want %b", c, lcofi_irq, m_lcofi); end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_event_count();
      test_wrap();
      test_write_collision();
      test_privilege();
      test_inhibit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
